// File: rtl/imem_loader.sv
// imem_loader: byte-addressed instruction memory for the SEQ core.
// Filled from a valid/ready byte stream, then serves a 10-byte fetch window.
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic [15:0] load_len,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  input  logic [63:0] f_pc,
  output logic [79:0] f_bytes,
  output logic        imem_error,
  output logic        cpu_run,
  output logic        load_fault,
  output logic [15:0] load_count,
  output logic [7:0]  load_xsum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_RUN   = 2'b10,
    S_FAULT = 2'b11
  } state_e;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [63:0] DEPTH_PC = 64'(DEPTH);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  xsum_q, xsum_d;
  logic        we;
  logic        len_bad;
  logic        last_idx;
  logic        pc_ok;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] raddr [10];

  assign len_bad  = (load_len == 16'd0) || ({1'b0, load_len} > DEPTH_W);
  assign last_idx = (cnt_q == len_q - 16'd1);
  assign pc_ok    = (f_pc < DEPTH_PC);

  assign s_ready    = (state_q == S_LOAD);
  assign cpu_run    = (state_q == S_RUN);
  assign load_fault = (state_q == S_FAULT);
  assign load_count = cnt_q;
  assign load_xsum  = xsum_q;

  // Next-state: start/length check outside LOAD, byte accounting inside it
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    xsum_d  = xsum_q;
    we      = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        if (s_valid) begin
          we     = 1'b1;
          cnt_d  = cnt_q + 16'd1;
          xsum_d = xsum_q ^ s_data;
          if (last_idx) begin
            state_d = s_last ? S_RUN : S_FAULT;
          end else if (s_last) begin
            state_d = S_FAULT;
          end
        end
      end
      S_IDLE, S_RUN, S_FAULT: begin
        if (load_start) begin
          if (len_bad) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_LOAD;
            len_d   = load_len;
            cnt_d   = 16'd0;
            xsum_d  = 8'd0;
          end
        end
      end
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 16'd0;
      cnt_q   <= 16'd0;
      xsum_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      xsum_q  <= xsum_d;
    end
  end

  // Memory write port; contents survive reset, a reset cycle blocks writes
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[cnt_q[AW-1:0]] <= s_data;
    end
  end

  // Window byte addresses, one extra bit to spot running off the top
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      raddr[i] = {1'b0, f_pc[AW-1:0]} + (AW+1)'(i);
    end
  end

  // Combinational fetch window; bytes past the top read as halt (00)
  always_comb begin
    f_bytes    = '0;
    imem_error = 1'b0;
    if (state_q == S_RUN) begin
      imem_error = !pc_ok;
      if (pc_ok) begin
        for (int i = 0; i < 10; i++) begin
          if (!raddr[i][AW]) begin
            f_bytes[8*i +: 8] = mem[raddr[i][AW-1:0]];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// Written bytes are queued on drive and popped when read back in RUN.
module tb_imem_loader;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [15:0] load_len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic [63:0] f_pc;
  logic [79:0] f_bytes;
  logic        imem_error;
  logic        cpu_run;
  logic        load_fault;
  logic [15:0] load_count;
  logic [7:0]  load_xsum;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_len   (load_len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .f_pc       (f_pc),
    .f_bytes    (f_bytes),
    .imem_error (imem_error),
    .cpu_run    (cpu_run),
    .load_fault (load_fault),
    .load_count (load_count),
    .load_xsum  (load_xsum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb [$];
  logic [7:0] mdl [DEPTH];
  int         m_st;
  int         m_len;
  int         m_cnt;
  logic [7:0] m_x;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int a, input logic [7:0] d);
    wr_t e;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].addr == a) sb.delete(i);
    end
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_rst(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    m_st  = 0;
    m_cnt = 0;
    m_x   = 8'h00;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = len[15:0];
    tick();
    load_start = 1'b0;
    if (m_st != 1) begin
      if (len == 0 || len > DEPTH) begin
        m_st = 3;
      end else begin
        m_st  = 1;
        m_len = len;
        m_cnt = 0;
        m_x   = 8'h00;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (m_st == 1) begin
      mdl[m_cnt] = d;
      sb_push(m_cnt, d);
      m_x = m_x ^ d;
      m_cnt++;
      if (m_cnt == m_len) m_st = last ? 2 : 3;
      else if (last) m_st = 3;
    end
  endtask

  task automatic chk_state(input string tag);
    check({tag, ".run"}, 80'(cpu_run), 80'(m_st == 2));
    check({tag, ".rdy"}, 80'(s_ready), 80'(m_st == 1));
    check({tag, ".flt"}, 80'(load_fault), 80'(m_st == 3));
    check({tag, ".cnt"}, 80'(load_count), 80'(m_cnt));
    check({tag, ".xsum"}, 80'(load_xsum), 80'(m_x));
  endtask

  function automatic logic [79:0] exp_win(input logic [63:0] pc);
    logic [79:0] w;
    w = '0;
    if (m_st == 2 && pc < 64'(DEPTH)) begin
      for (int i = 0; i < 10; i++) begin
        if (int'(pc) + i < DEPTH) w[8*i +: 8] = mdl[int'(pc) + i];
      end
    end
    return w;
  endfunction

  task automatic rd_win(input string tag, input logic [63:0] pc);
    @(negedge clk);
    f_pc = pc;
    #1;
    check({tag, ".win"}, f_bytes, exp_win(pc));
    check({tag, ".err"}, 80'(imem_error),
          80'(m_st == 2 && pc >= 64'(DEPTH)));
  endtask

  task automatic drain();
    wr_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      f_pc = 64'(e.addr);
      #1;
      check("sb", 80'(f_bytes[7:0]), 80'(e.data));
    end
  endtask

  task automatic load_nominal(input string tag);
    start_load(4);
    chk_state({tag, ".ld"});
    send(8'h30, 1'b0);
    send(8'hF2, 1'b0);
    send(8'h0A, 1'b0);
    send(8'h00, 1'b1);
    chk_state(tag);
  endtask

  initial begin
    rst        = 1'b0;
    load_start = 1'b0;
    load_len   = 16'd0;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    s_last     = 1'b0;
    f_pc       = 64'd0;
    m_st       = 0;
    m_len      = 0;
    m_cnt      = 0;
    m_x        = 8'h00;

    do_rst(2);
    chk_state("rst");
    rd_win("rst", 64'd0);

    start_load(DEPTH);
    chk_state("pre.ld");
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] d;
      d = 8'h00;
      if (i == DEPTH - 3) d = 8'hA1;
      if (i == DEPTH - 2) d = 8'hB2;
      if (i == DEPTH - 1) d = 8'hC3;
      send(d, i == DEPTH - 1);
    end
    chk_state("pre");
    drain();

    load_nominal("nom");
    check("nom.run1", 80'(cpu_run), 80'd1);
    check("nom.cnt4", 80'(load_count), 80'd4);
    check("nom.xC8", 80'(load_xsum), 80'hC8);
    rd_win("nom", 64'd0);
    check("nom.word", f_bytes, 80'h000AF230);
    drain();

    start_load(4);
    send(8'h30, 1'b0);
    send(8'hF2, 1'b0);
    s_data = 8'hEE;
    s_last = 1'b1;
    repeat (3) tick();
    s_last = 1'b0;
    chk_state("gap.mid");
    send(8'h0A, 1'b0);
    send(8'h00, 1'b1);
    chk_state("gap");
    check("gap.xC8", 80'(load_xsum), 80'hC8);
    rd_win("gap", 64'd0);
    drain();

    start_load(4);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    chk_state("early");
    check("early.cnt2", 80'(load_count), 80'd2);
    send(8'h99, 1'b0);
    chk_state("early.ign");
    load_nominal("early.rec");
    drain();

    start_load(0);
    chk_state("len0");
    load_nominal("len0.rec");

    start_load(DEPTH + 1);
    chk_state("lenbig");
    load_nominal("lenbig.rec");
    drain();

    rd_win("top", 64'(DEPTH - 3));
    check("top.word", f_bytes, 80'hC3B2A1);
    rd_win("top1", 64'(DEPTH - 1));
    rd_win("depth", 64'(DEPTH));
    check("depth.err1", 80'(imem_error), 80'd1);
    rd_win("msb", 64'h8000_0000_0000_0000);
    rd_win("alias", 64'h0001_0000_0000_0000);

    start_load(4);
    send(8'h30, 1'b0);
    load_start = 1'b1;
    load_len   = 16'd2;
    send(8'hF2, 1'b0);
    load_start = 1'b0;
    chk_state("busy.mid");
    send(8'h0A, 1'b0);
    send(8'h00, 1'b1);
    chk_state("busy");
    drain();

    start_load(4);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    do_rst(1);
    chk_state("mrst");
    rd_win("mrst", 64'd0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b1);
    chk_state("mrst.ign");
    start_load(1);
    send(8'h55, 1'b1);
    chk_state("mrst.rec");
    rd_win("mrst.rec", 64'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
